if_id_hazard_ctrl: RTL
======================

Name: if_id_hazard_ctrl

Overview:
Pipeline sequencing controller for the IF/ID register and the PC of the 5-stage MIPS pipeline.
- Detects load-use hazards between the instruction in ID and a load in EX.
- Squashes wrong-path fetches after a taken branch resolves in EX.
- Holds fetch while instruction memory is not ready.
- Drives the IF/ID write-enable and flush, the PC write-enable and the ID/EX bubble insert. Keeps a stall performance counter.

Parameters:
REG_ADDR_W, 5, register specifier width
FLUSH_CYCLES, 1, bubble cycles after taken branch (legal 1..3)
CNT_W, 16, stall counter width

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-high
id_instr  in  32  instruction currently held in IF/ID (opcode [31:26], rs [25:21], rt [20:16])
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_ADDR_W  destination register of the EX load
branch_taken  in  1  taken branch/jump resolved in EX this cycle
imem_ready  in  1  instruction memory returns valid data this cycle
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clears to NOP (0x00000000) at next edge
id_ex_bubble  out  1  ID/EX control fields zeroed at next edge
state  out  2  debug: current FSM state
stall_count  out  CNT_W  cycles with pc_write=0, saturating

Behaviour:
- One clock and one reset. `reset` is asynchronous and active-high. The ports are named `clk` and `reset`.
- While `reset` is high, outputs are forced combinationally:
  - pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
  - state=RUN(0), stall_count=0, flush counter=0.
- Hazard detect `hz` (combinational):
  - hz = ex_mem_read && ex_rt!=0 && (ex_rt==rs || (uses_rt && ex_rt==rt)).
  - uses_rt is true for opcode 0x00 (R-type), 0x04 (beq), 0x05 (bne) and 0x2B (sw). It is false for all other opcodes, including lw (0x23).
- FSM states: RUN=0, LOAD_STALL=1, FLUSH=2, IMEM_WAIT=3. Outputs are combinational from state and inputs. Priority in every state except FLUSH: branch_taken > !imem_ready > hz.
- Action sets:
  - Normal: pc_write=1, if_id_write=1, flush=0, bubble=0.
  - Branch: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1. The flush counter loads FLUSH_CYCLES-1. Next state is FLUSH if FLUSH_CYCLES>1, else RUN.
  - Hold: pc_write=0, if_id_write=0, id_ex_bubble=1, flush=0.
- RUN:
  - branch_taken -> Branch.
  - else !imem_ready -> Hold, next IMEM_WAIT.
  - else hz -> Hold, next LOAD_STALL.
  - else Normal, stay in RUN.
- LOAD_STALL (exactly one cycle):
  - hz is masked, because EX now holds the bubble.
  - branch_taken -> Branch.
  - else !imem_ready -> Hold, next IMEM_WAIT.
  - else Normal, next RUN.
- FLUSH:
  - Outputs as in Branch; the counter decrements each cycle.
  - When the counter reaches 1 (checked before decrement), next state is RUN.
  - branch_taken is ignored here, since the flushed instruction is wrong-path.
- IMEM_WAIT:
  - branch_taken -> Branch (the redirect wins over the wait).
  - else !imem_ready -> Hold, stay.
  - else Normal, next RUN. hz is re-evaluated only once back in RUN.
- stall_count increments on each clock edge where pc_write==0 and reset is low. It holds at all-ones.
- Reset mid-operation: the FSM returns to RUN immediately and any pending flush count is discarded.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, LOAD_STALL, FLUSH, IMEM_WAIT);
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_LW, OP_SW;
  - field bit positions for opcode, rs and rt;
  - the NOP constant 32'h00000000.
- One sub-module, load_use_detect: purely combinational. Inputs are id_instr, ex_mem_read and ex_rt; output is hz.

Test Plan:
- Reset: reset=1 for 10 ns -> pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, state=0, stall_count=0. After release with no hazard -> pc_write=1, if_id_write=1.
- Load-use: id_instr=0x01094020 (add rs=8, rt=9), ex_mem_read=1, ex_rt=9 -> one cycle of pc_write=0, if_id_write=0, bubble=1. Next cycle state=1 and writes=1 even with ex_mem_read still 1. stall_count=1.
- No false stall:
  - id_instr=0x8C090004 (lw rs=0, rt=9), ex_mem_read=1, ex_rt=9 -> no stall, since lw does not read rt.
  - id_instr=0xAC080008 (sw rt=8), ex_rt=8 -> stall of 1 cycle.
  - ex_rt=0 -> never stalls.
- Branch flush with FLUSH_CYCLES=2: branch_taken pulse for 1 cycle -> if_id_flush=1 and id_ex_bubble=1 for exactly 2 cycles, pc_write=1 throughout, then RUN. A second branch_taken in the FLUSH cycle has no effect.
- IMEM wait: imem_ready=0 for 3 cycles -> pc_write=0 for 3 cycles, state=3, stall_count+=3. Asserting branch_taken in the 2nd wait cycle -> immediate flush with pc_write=1.
- Reset mid-FLUSH (FLUSH_CYCLES=3): assert reset asynchronously between edges in the 2nd flush cycle -> state=0 without waiting for a clock edge, stall_count=0. After release -> Normal outputs.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the IF/ID sequencing controller.
// Holds the state encoding, the MIPS opcodes and the instruction field positions.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    IMEM_WAIT  = 2'd3
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;

  localparam logic [31:0] NOP = 32'h0000_0000;

  // Only these opcodes read rt as a source; a load writes it instead.
  function automatic logic uses_rt(input logic [5:0] opc);
    case (opc)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: return 1'b1;
      OP_LW:                           return 1'b0;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: ID source register matches the destination of a load in EX.
// Purely combinational, zero latency; no flow control of its own.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [31:0]           id_instr,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  hz
);

  logic [REG_ADDR_W-1:0] rs;
  logic [REG_ADDR_W-1:0] rt;
  logic                  unused_imm;

  assign rs         = REG_ADDR_W'(id_instr[RS_MSB:RS_LSB]);
  assign rt         = REG_ADDR_W'(id_instr[RT_MSB:RT_LSB]);
  assign unused_imm = ^id_instr[15:0];

  // $zero is never a real dependency.
  assign hz = ex_mem_read && (ex_rt != '0) &&
              ((ex_rt == rs) || (uses_rt(id_instr[OPC_MSB:OPC_LSB]) && (ex_rt == rt)));

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID and PC sequencing: load-use stall, branch squash, imem wait; combinational outputs.
// Backpressure: holds PC and IF/ID (bubble into ID/EX) while imem is not ready or on load-use.
module if_id_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           id_instr,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic [1:0]            state,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_e     st_q, st_d;
  logic [1:0] fcnt_q, fcnt_d;
  logic       hz;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_lud (
    .id_instr    (id_instr),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hz          (hz)
  );

  always_comb begin
    st_d         = st_q;
    fcnt_d       = fcnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (st_q == FLUSH) begin
      // Wrong-path slot: a branch seen here is itself squashed.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      fcnt_d       = fcnt_q - 2'd1;
      if (fcnt_q <= 2'd1) st_d = RUN;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      fcnt_d       = FLUSH_LOAD;
      st_d         = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else if (!imem_ready) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      st_d         = IMEM_WAIT;
    end else if (hz && (st_q == RUN)) begin
      // Out of LOAD_STALL the load has moved on and EX carries the bubble.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      st_d         = LOAD_STALL;
    end else begin
      st_d         = RUN;
    end
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= RUN;
      fcnt_q      <= 2'd0;
      stall_count <= '0;
    end else begin
      st_q   <= st_d;
      fcnt_q <= fcnt_d;
      if (!pc_write && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end
  end

  assign state = st_q;

endmodule
